// File: rtl/fetch_unit.sv
// Purpose: PC, instruction register and ALUOut holding stage of a multicycle core, with imem wait handling.
// Latency: IR, PC and ALUOut update at the edge after the request; field decode and imem_addr are combinational.
// Backpressure: an IR load without imem_valid raises stall the same cycle until imem_valid returns.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IRWrite,
  input  logic        PCWrite,
  input  logic        PCSrc,
  input  logic [31:0] ALUResult,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] imem_addr,
  output logic [31:0] PC,
  output logic [5:0]  Opcode,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic [4:0]  Shamt,
  output logic [5:0]  Funct,
  output logic [31:0] SignImm,
  output logic [31:0] ALUOut,
  output logic        stall,
  output logic        align_err,
  output logic [15:0] fetch_count,
  output logic [15:0] stall_cycles
);

  typedef enum logic {
    ST_READY = 1'b0,
    ST_WAIT  = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_aluout;
  logic        r_pend_vld;
  logic [31:0] r_pend_pc;
  logic [15:0] r_fetch_count;
  logic [15:0] r_stall_cycles;
  logic        r_align_err;

  state_t      w_next_state;
  logic        w_stall;
  logic        w_ir_load;
  logic        w_pc_load;
  logic [31:0] w_pc_next;
  logic        w_pend_capture;
  logic [31:0] w_sel_pc;

  // Candidate next PC from the controller's chosen source.
  assign w_sel_pc = PCSrc ? r_aluout : ALUResult;

  // Next-state and per-cycle action decode; all controller inputs are ignored while waiting.
  always_comb begin
    w_next_state   = r_state;
    w_stall        = 1'b0;
    w_ir_load      = 1'b0;
    w_pc_load      = 1'b0;
    w_pc_next      = w_sel_pc;
    w_pend_capture = 1'b0;
    case (r_state)
      ST_READY: begin
        if (IRWrite && !imem_valid) begin
          // Freeze everything and remember the PC update the controller asked for.
          w_stall        = 1'b1;
          w_pend_capture = 1'b1;
          w_next_state   = ST_WAIT;
        end else begin
          w_ir_load = IRWrite;
          w_pc_load = PCWrite;
        end
      end
      ST_WAIT: begin
        w_stall = 1'b1;
        if (imem_valid) begin
          w_ir_load    = 1'b1;
          w_pc_load    = r_pend_vld;
          w_pc_next    = r_pend_pc;
          w_next_state = ST_READY;
        end
      end
      default: w_next_state = ST_READY;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_READY;
    else       r_state <= w_next_state;
  end

  // PC update and one-cycle misalignment flag for the write that just happened.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_align_err <= 1'b0;
    end else begin
      r_align_err <= w_pc_load && (w_pc_next[1:0] != 2'b00);
      if (w_pc_load) r_pc <= w_pc_next;
    end
  end

  // Instruction register load.
  always_ff @(posedge clk) begin
    if (reset)          r_ir <= 32'h0;
    else if (w_ir_load) r_ir <= imem_rdata;
  end

  // ALUOut follows ALUResult except while stalled.
  always_ff @(posedge clk) begin
    if (reset)         r_aluout <= 32'h0;
    else if (!w_stall) r_aluout <= ALUResult;
  end

  // Pending PC write captured on WAIT entry; dropped once applied or on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_vld <= 1'b0;
      r_pend_pc  <= 32'h0;
    end else if (w_pend_capture) begin
      r_pend_vld <= PCWrite;
      r_pend_pc  <= w_sel_pc;
    end else if (r_state == ST_WAIT && imem_valid) begin
      r_pend_vld <= 1'b0;
    end
  end

  // Fetch counter wraps; stall counter saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_count  <= 16'h0;
      r_stall_cycles <= 16'h0;
    end else begin
      if (w_ir_load) r_fetch_count <= r_fetch_count + 16'd1;
      if (w_stall && r_stall_cycles != 16'hFFFF) r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign imem_addr    = r_pc;
  assign PC           = r_pc;
  assign Opcode       = r_ir[31:26];
  assign Rs           = r_ir[25:21];
  assign Rt           = r_ir[20:16];
  assign Rd           = r_ir[15:11];
  assign Shamt        = r_ir[10:6];
  assign Funct        = r_ir[5:0];
  assign SignImm      = {{16{r_ir[15]}}, r_ir[15:0]};
  assign ALUOut       = r_aluout;
  assign stall        = w_stall;
  assign align_err    = r_align_err;
  assign fetch_count  = r_fetch_count;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: loaded instructions go through an expected-IR queue.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled 2 units after.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        IRWrite;
  logic        PCWrite;
  logic        PCSrc;
  logic [31:0] ALUResult;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic [31:0] PC;
  logic [5:0]  Opcode;
  logic [4:0]  Rs, Rt, Rd, Shamt;
  logic [5:0]  Funct;
  logic [31:0] SignImm;
  logic [31:0] ALUOut;
  logic        stall;
  logic        align_err;
  logic [15:0] fetch_count;
  logic [15:0] stall_cycles;

  logic [31:0] ir_view;
  logic [31:0] sb_q[$];
  int          n_err = 0;
  int          n_chk = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .ALUResult(ALUResult), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .imem_addr(imem_addr), .PC(PC), .Opcode(Opcode), .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .Shamt(Shamt), .Funct(Funct), .SignImm(SignImm), .ALUOut(ALUOut), .stall(stall),
    .align_err(align_err), .fetch_count(fetch_count), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  assign ir_view = {Opcode, Rs, Rt, Rd, Shamt, Funct};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] v);
    sb_q.push_back(v);
  endtask

  task automatic sb_pop_check(input string tag);
    logic [31:0] exp;
    if (sb_q.size() == 0) begin
      n_chk++;
      n_err++;
      $error("FAIL %s: observed=%h expected=<empty scoreboard>", tag, ir_view);
    end else begin
      exp = sb_q.pop_front();
      chk(tag, ir_view, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    imem_valid = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    ALUResult  = 32'h0;
    imem_rdata = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    // Reset state
    chk("rst_pc", PC, 32'h0);
    chk("rst_ir", ir_view, 32'h0);
    chk("rst_aluout", ALUOut, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_align", 32'(align_err), 32'h0);
    chk("rst_fcnt", 32'(fetch_count), 32'h0);
    chk("rst_scnt", 32'(stall_cycles), 32'h0);

    // Fetch with simultaneous PC write; the fetch uses the old PC
    IRWrite = 1'b1; imem_valid = 1'b1; imem_rdata = 32'h8C22_0004;
    PCWrite = 1'b1; PCSrc = 1'b0; ALUResult = 32'd4;
    sb_push(32'h8C22_0004);
    #1;
    chk("f1_addr_old_pc", imem_addr, 32'h0);
    chk("f1_no_stall", 32'(stall), 32'h0);
    tick();
    idle_inputs();
    #1;
    sb_pop_check("f1_ir");
    chk("f1_opcode", 32'(Opcode), 32'h23);
    chk("f1_rs", 32'(Rs), 32'd1);
    chk("f1_rt", 32'(Rt), 32'd2);
    chk("f1_signimm", SignImm, 32'd4);
    chk("f1_pc", PC, 32'd4);
    chk("f1_addr", imem_addr, 32'd4);
    chk("f1_fcnt", 32'(fetch_count), 32'd1);
    chk("f1_aluout", ALUOut, 32'd4);

    // Three-cycle memory wait with a pending PC write of 8
    IRWrite = 1'b1; imem_valid = 1'b0; imem_rdata = 32'hBAD0_BAD0;
    PCWrite = 1'b1; PCSrc = 1'b0; ALUResult = 32'd8;
    #1;
    chk("w_entry_stall", 32'(stall), 32'h1);
    tick();
    IRWrite = 1'b0; PCWrite = 1'b1; PCSrc = 1'b1; ALUResult = 32'hDEAD_0000;
    #1;
    chk("w1_stall", 32'(stall), 32'h1);
    chk("w1_pc_hold", PC, 32'd4);
    tick();
    #1;
    chk("w2_stall", 32'(stall), 32'h1);
    chk("w2_aluout_hold", ALUOut, 32'd4);
    tick();
    imem_valid = 1'b1; imem_rdata = 32'hFFFF_8123;
    sb_push(32'hFFFF_8123);
    #1;
    chk("w3_stall", 32'(stall), 32'h1);
    chk("w3_pc_hold", PC, 32'd4);
    tick();
    idle_inputs();
    #1;
    chk("rel_stall", 32'(stall), 32'h0);
    chk("rel_scnt", 32'(stall_cycles), 32'd4);
    chk("rel_pc", PC, 32'd8);
    sb_pop_check("rel_ir");
    chk("rel_signimm", SignImm, 32'hFFFF_8123);
    chk("rel_fcnt", 32'(fetch_count), 32'd2);
    chk("rel_aluout", ALUOut, 32'd4);

    // Branch through ALUOut
    ALUResult = 32'h100;
    tick();
    #1;
    chk("br_aluout", ALUOut, 32'h100);
    PCWrite = 1'b1; PCSrc = 1'b1; ALUResult = 32'h0;
    tick();
    idle_inputs();
    #1;
    chk("br_pc", PC, 32'h100);
    chk("br_align", 32'(align_err), 32'h0);

    // Misaligned PC write
    PCWrite = 1'b1; PCSrc = 1'b0; ALUResult = 32'h6;
    tick();
    idle_inputs();
    #1;
    chk("mis_pc", PC, 32'h6);
    chk("mis_align_hi", 32'(align_err), 32'h1);
    tick();
    #1;
    chk("mis_align_lo", 32'(align_err), 32'h0);
    chk("mis_pc_hold", PC, 32'h6);

    // Reset while waiting discards the pending PC write
    IRWrite = 1'b1; imem_valid = 1'b0; PCWrite = 1'b1; PCSrc = 1'b0; ALUResult = 32'h200;
    tick();
    IRWrite = 1'b0; PCWrite = 1'b0;
    #1;
    chk("rw_stall", 32'(stall), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rw_pc", PC, 32'h0);
    chk("rw_stall_lo", 32'(stall), 32'h0);
    chk("rw_fcnt", 32'(fetch_count), 32'h0);
    chk("rw_scnt", 32'(stall_cycles), 32'h0);
    imem_valid = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick();
    imem_valid = 1'b0;
    #1;
    chk("rw_ir_zero", ir_view, 32'h0);
    chk("rw_pc_zero", PC, 32'h0);

    // Fetch counter wrap
    IRWrite = 1'b1; imem_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      imem_rdata = 32'(i);
      tick();
    end
    #1;
    chk("wrap_ffff", 32'(fetch_count), 32'hFFFF);
    chk("wrap_ir_last", ir_view, 32'd65534);
    imem_rdata = 32'h1234_5678;
    sb_push(32'h1234_5678);
    tick();
    idle_inputs();
    #1;
    chk("wrap_zero", 32'(fetch_count), 32'h0);
    sb_pop_check("wrap_ir");
    chk("wrap_sb_empty", 32'(sb_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: IRWrite  input  1  main controller request to load the instruction register from instruction memory.
REQ-005 Port: PCWrite  input  1  main controller request to update PC.
REQ-006 Port: PCSrc  input  1  PC source select: 0 = ALUResult, 1 = ALUOut.
REQ-007 Port: ALUResult  input  32  current-cycle ALU output.
REQ-008 Port: imem_rdata  input  32  instruction memory read data.
REQ-009 Port: imem_valid  input  1  imem_rdata is valid for imem_addr this cycle.
REQ-010 Port: imem_addr  output  32  instruction fetch address.
REQ-011 Port: PC  output  32  current program counter.
REQ-012 Port: Opcode  output  6  IR[31:26].
REQ-013 Port: Rs, Rt, Rd, Shamt  output  5 each  IR[25:21], IR[20:16], IR[15:11], IR[10:6].
REQ-014 Port: Funct  output  6  IR[5:0].
REQ-015 Port: SignImm  output  32  IR[15:0] sign-extended.
REQ-016 Port: ALUOut  output  32  registered ALUResult.
REQ-017 Port: stall  output  1  controller must hold its state while high.
REQ-018 Port: align_err  output  1  one-cycle pulse on write of a non-word-aligned PC.
REQ-019 Port: fetch_count  output  16  number of IR loads, wraps 16'hFFFF -> 0.
REQ-020 Port: stall_cycles  output  16  cycles with stall high, saturates at 16'hFFFF.

Function
REQ-021 imem_addr SHALL equal PC combinationally; field outputs SHALL decode IR combinationally.
REQ-022 FSM states: READY, WAIT.
REQ-023 READY, IRWrite=1, imem_valid=1: IR <= imem_rdata, fetch_count++, stay READY.
REQ-024 READY, IRWrite=1, imem_valid=0: stall=1 in the same cycle (combinational); IR, PC, ALUOut unchanged; capture PCWrite, PCSrc and the selected next-PC value as pending; go to WAIT.
REQ-025 WAIT: stall=1; IRWrite, PCWrite, PCSrc, ALUResult ignored; stall_cycles increments (saturating) each WAIT cycle and on the entry cycle.
REQ-026 WAIT, imem_valid=1: IR <= imem_rdata, fetch_count++, apply pending PC write if captured, stall=1 still this cycle, next state READY (stall low next cycle).
REQ-027 READY, PCWrite=1 and not stalling: PC <= (PCSrc ? ALUOut : ALUResult) at the edge; simultaneous IRWrite load uses old PC address.
REQ-028 ALUOut <= ALUResult every cycle with stall=0; held while stall=1.
REQ-029 A PC write with next-PC[1:0] != 0 SHALL still load PC and pulse align_err for exactly the cycle after the write.
REQ-030 PCWrite=0 holds PC; IRWrite=0 holds IR; no IRWrite never enters WAIT.
REQ-031 fetch_count wraps modulo 2^16; stall_cycles never wraps.

Reset
REQ-032 reset=1 at an edge: PC=RESET_PC, IR=0, ALUOut=0, state READY, pending cleared, fetch_count=0, stall_cycles=0, align_err=0; stall=0 the cycle after.
REQ-033 reset SHALL take priority over all inputs, including mid-WAIT; a pending PC write is discarded.

Verification
REQ-034 Reset, then IRWrite=1, imem_valid=1, imem_rdata=32'h8C22_0004, PCWrite=1, PCSrc=0, ALUResult=4 -> next cycle IR loaded, Opcode=6'h23, Rs=1, Rt=2, SignImm=4, PC=4, fetch_count=1.
REQ-035 IRWrite=1, imem_valid=0 for 3 cycles then 1, PCWrite=1, ALUResult=8 at entry -> stall high 4 cycles, stall_cycles=4, PC stays 4 until release edge then 8, IR = data presented on release.
REQ-036 Branch: ALUResult=32'h100 one cycle (ALUOut=32'h100), next cycle PCWrite=1, PCSrc=1, ALUResult=32'h0 -> PC=32'h100.
REQ-037 PCWrite=1, PCSrc=0, ALUResult=32'h0000_0006 -> PC=6, align_err high exactly one cycle.
REQ-038 Enter WAIT with pending PCWrite, assert reset -> PC=RESET_PC, stall low, counters 0; imem_valid=1 afterwards without IRWrite leaves IR=0.
REQ-039 Force fetch_count to 16'hFFFF via 65535 loads, one more load -> fetch_count=0.
